stopwatch_ctrl: RTL

//   Consumer side of the stopwatch button synchronizer. Takes the synchronized

---
 rtl/stopwatch_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch core: button edge detect, IDLE/RUN/STOP FSM, 10 ms prescaler, MM:SS.cc BCD digits.
// Outputs are registered; the digits and O_TICK/O_OVF change together on the tick edge.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 160000,
  parameter int PRE_W    = 18
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic       I_START_EN,
  input  logic       I_CLR_EN,
  output logic       O_RUN,
  output logic       O_TICK,
  output logic       O_OVF,
  output logic [3:0] O_CS_ONES,
  output logic [3:0] O_CS_TENS,
  output logic [3:0] O_SEC_ONES,
  output logic [3:0] O_SEC_TENS,
  output logic [3:0] O_MIN_ONES,
  output logic [3:0] O_MIN_TENS
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_start_q;
  logic             r_clr_q;
  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_cs_ones, r_cs_tens, r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
  logic             r_run, r_tick, r_ovf;

  logic w_start_rise, w_clr_rise;
  logic w_clear, w_count, w_tick;
  logic w_c_cs1, w_c_cs10, w_c_s1, w_c_s10, w_c_m1, w_ovf;

  assign w_start_rise = I_START_EN & ~r_start_q;
  assign w_clr_rise   = I_CLR_EN & ~r_clr_q;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b1;
      r_clr_q   <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_start_q <= I_START_EN;
      r_clr_q   <= I_CLR_EN;
    end
  end

  // Clear wins over start in STOP; in RUN a start press pauses without counting that edge.
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_count = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_rise) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_start_rise) w_next = ST_STOP;
        else              w_count = 1'b1;
      end
      ST_STOP: begin
        if (w_clr_rise) begin
          w_next  = ST_IDLE;
          w_clear = 1'b1;
        end else if (w_start_rise) begin
          w_next = ST_RUN;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_tick   = w_count && (r_pre == TICK_LAST);
  assign w_c_cs1  = w_tick   && (r_cs_ones  == 4'd9);
  assign w_c_cs10 = w_c_cs1  && (r_cs_tens  == 4'd9);
  assign w_c_s1   = w_c_cs10 && (r_sec_ones == 4'd9);
  assign w_c_s10  = w_c_s1   && (r_sec_tens == 4'd5);
  assign w_c_m1   = w_c_s10  && (r_min_ones == 4'd9);
  assign w_ovf    = w_c_m1   && (r_min_tens == 4'd5);

  always_ff @(posedge I_CLK) begin
    if (I_RST || w_clear)  r_pre <= '0;
    else if (w_tick)       r_pre <= '0;
    else if (w_count)      r_pre <= r_pre + 1'b1;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST || w_clear) begin
      r_cs_ones  <= 4'd0;
      r_cs_tens  <= 4'd0;
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
    end else begin
      if (w_tick)   r_cs_ones  <= w_c_cs1  ? 4'd0 : r_cs_ones  + 4'd1;
      if (w_c_cs1)  r_cs_tens  <= w_c_cs10 ? 4'd0 : r_cs_tens  + 4'd1;
      if (w_c_cs10) r_sec_ones <= w_c_s1   ? 4'd0 : r_sec_ones + 4'd1;
      if (w_c_s1)   r_sec_tens <= w_c_s10  ? 4'd0 : r_sec_tens + 4'd1;
      if (w_c_s10)  r_min_ones <= w_c_m1   ? 4'd0 : r_min_ones + 4'd1;
      if (w_c_m1)   r_min_tens <= w_ovf    ? 4'd0 : r_min_tens + 4'd1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_run  <= 1'b0;
      r_tick <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_run  <= (w_next == ST_RUN);
      r_tick <= w_tick;
      r_ovf  <= w_ovf;
    end
  end

  assign O_RUN      = r_run;
  assign O_TICK     = r_tick;
  assign O_OVF      = r_ovf;
  assign O_CS_ONES  = r_cs_ones;
  assign O_CS_TENS  = r_cs_tens;
  assign O_SEC_ONES = r_sec_ones;
  assign O_SEC_TENS = r_sec_tens;
  assign O_MIN_ONES = r_min_ones;
  assign O_MIN_TENS = r_min_tens;

endmodule
